pipe_mem_arbiter: RTL

- Shares one variable-latency memory port between two requesters in the pipelined CPU: instruction fetch (IF) and the MEM-stage load/store unit (D).
- Grants one transaction at a time and drives the shared port from registers.
- Returns read data and a one-cycle ack to the winning requester, and raises stall signals for the pipeline while a request is outstanding.
- Data has priority, with an anti-starvation guard for fetch and a timeout for a dead memory.

---
 rtl/pipe_mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch (IF)
// and the MEM-stage load/store unit (D). Data wins ties, except that IF is
// granted after MAX_DATA_STREAK consecutive D grants that kept IF waiting.
// A transaction with no mem_ack for TIMEOUT busy cycles is aborted with err.
//
// Ports:
//   clk, reset (async, active low)
//   if_req/if_addr        -> if_ack/if_rdata       fetch side
//   d_req/d_we/d_addr/d_wdata/d_size -> d_ack/d_rdata  data side
//   err                   valid with an ack pulse; 1 = timed out
//   stall_if, stall_mem   combinational pipeline stalls
//   mem_req/we/addr/wdata/size (registered) and mem_ack/mem_rdata: shared port
module pipe_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [3:0]  d_size,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        err,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_size,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] streak, streak_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          mem_req_nx, mem_we_nx, if_ack_nx, d_ack_nx, err_nx;
  logic [63:0]   mem_addr_nx, mem_wdata_nx, d_rdata_nx;
  logic [3:0]    mem_size_nx;
  logic [31:0]   if_rdata_nx;
  logic          grant_d;

  // Stalls are qualified by reset so they read 0 while reset is held.
  assign stall_if  = reset & if_req & ~if_ack;
  assign stall_mem = reset & d_req & ~d_ack;

  // D wins unless IF is waiting and the data streak has hit its limit.
  assign grant_d = d_req & ~(if_req & (streak == SW'(MAX_DATA_STREAK)));

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state;
    streak_nx    = streak;
    tcnt_nx      = tcnt;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    mem_size_nx  = mem_size;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;
    if_ack_nx    = 1'b0;
    d_ack_nx     = 1'b0;
    err_nx       = 1'b0;

    unique case (state)
      IDLE: begin
        tcnt_nx = '0;
        if (grant_d) begin
          state_nx     = BUSY_D;
          mem_req_nx   = 1'b1;
          mem_we_nx    = d_we;
          mem_addr_nx  = d_addr;
          mem_wdata_nx = d_wdata;
          mem_size_nx  = d_size;
          if (!if_req)
            streak_nx = '0;
          else if (streak != SW'(MAX_DATA_STREAK))
            streak_nx = streak + SW'(1);
        end else if (if_req) begin
          state_nx     = BUSY_IF;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = if_addr;
          mem_wdata_nx = '0;
          mem_size_nx  = 4'd4;
          streak_nx    = '0;
        end
      end

      BUSY_IF, BUSY_D: begin
        if (mem_ack || tcnt == TW'(TIMEOUT - 1)) begin
          // Completion or abort: both end in RESP with a one-cycle ack.
          state_nx   = RESP;
          mem_req_nx = 1'b0;
          err_nx     = ~mem_ack;
          if (state == BUSY_IF) begin
            if_ack_nx   = 1'b1;
            if_rdata_nx = mem_ack ? mem_rdata[31:0] : 32'd0;
          end else begin
            d_ack_nx   = 1'b1;
            d_rdata_nx = mem_ack ? mem_rdata : 64'd0;
          end
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end

      RESP: state_nx = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      tcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      streak    <= streak_nx;
      tcnt      <= tcnt_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      mem_size  <= mem_size_nx;
      if_ack    <= if_ack_nx;
      d_ack     <= d_ack_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      err       <= err_nx;
    end
  end

endmodule
